// File: rtl/envelope_follower_pkg.sv
// Shared definitions for the envelope follower and other amplitude-domain blocks:
// default widths, offset-binary helpers and the slew decision encoding.
package envelope_follower_pkg;

    localparam int DEF_DATA_BITS      = 12;
    localparam int DEF_AMPLITUDE_BITS = 8;
    localparam int DEF_FRAC_BITS      = 8;
    localparam int DEF_HOLD_SAMPLES   = 4;

    typedef enum logic [1:0] {
        SLEW_IDLE,
        SLEW_ATTACK,
        SLEW_HOLD,
        SLEW_RELEASE
    } slew_op_e;

    // XOR with this mask converts offset binary to two's complement and back.
    function automatic logic [31:0] sign_mask(input int bits);
        return 32'h1 << (bits - 1);
    endfunction

    // Magnitude of a sign-extended sample, clamped so the most negative code
    // folds onto the largest positive one instead of overflowing.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int bits);
        logic [31:0] lim;
        logic [31:0] m;
        lim = (32'h1 << (bits - 1)) - 32'h1;
        m   = v[31] ? 32'(-v) : 32'(v);
        return (m > lim) ? lim : m;
    endfunction

endpackage

// File: rtl/envelope_follower_if.sv
// Sample-in / amplitude-out bundle of the envelope follower.
// master drives samples and rate controls; slave returns the envelope.
interface envelope_follower_if
    import envelope_follower_pkg::*;
#(
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int AMPLITUDE_BITS = DEF_AMPLITUDE_BITS
);
    logic [DATA_BITS-1:0]      din;
    logic                      din_valid;
    logic [3:0]                attack_shift;
    logic [3:0]                release_shift;
    logic [AMPLITUDE_BITS-1:0] amplitude;
    logic                      amp_valid;

    modport master (
        output din, din_valid, attack_shift, release_shift,
        input  amplitude, amp_valid
    );

    modport slave (
        input  din, din_valid, attack_shift, release_shift,
        output amplitude, amp_valid
    );
endinterface

// File: rtl/envelope_follower_env_slew.sv
// Peak-tracking accumulator: attack toward higher targets, hold, then release;
// one update per qualified target, result one clock later, no backpressure.
module env_slew
    import envelope_follower_pkg::*;
#(
    parameter int ACC_BITS     = DEF_AMPLITUDE_BITS + DEF_FRAC_BITS,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ACC_BITS-1:0] tgt_acc,
    input  logic                tgt_vld,
    input  logic [3:0]          attack_shift,
    input  logic [3:0]          release_shift,
    output logic [ACC_BITS-1:0] env,
    output logic                env_vld
);
    localparam int HOLD_RAW = $clog2(HOLD_SAMPLES + 1);
    localparam int HCW      = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam logic [HCW-1:0]      HOLD_LOAD = HCW'(HOLD_SAMPLES);
    localparam logic [ACC_BITS-1:0] ONE       = ACC_BITS'(1);

    logic [ACC_BITS-1:0] env_q, env_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic                env_vld_q, env_vld_d;
    slew_op_e            op;
    logic [ACC_BITS-1:0] diff_up, diff_dn, step_up, step_dn;

    always_comb begin
        op = SLEW_IDLE;
        if (tgt_vld) begin
            if (tgt_acc >= env_q)
                op = SLEW_ATTACK;
            else if (hold_cnt_q != '0)
                op = SLEW_HOLD;
            else
                op = SLEW_RELEASE;
        end
    end

    // Each step is bounded by its own difference, so env lands on the target
    // at worst and can never overshoot or wrap.
    always_comb begin
        diff_up = tgt_acc - env_q;
        diff_dn = env_q - tgt_acc;
        step_up = diff_up >> attack_shift;
        step_dn = diff_dn >> release_shift;
        if (step_up == '0 && diff_up != '0)
            step_up = ONE;
        if (step_dn == '0 && diff_dn != '0)
            step_dn = ONE;

        env_d      = env_q;
        hold_cnt_d = hold_cnt_q;
        env_vld_d  = tgt_vld;
        case (op)
            SLEW_ATTACK: begin
                env_d      = env_q + step_up;
                hold_cnt_d = HOLD_LOAD;
            end
            SLEW_HOLD:    hold_cnt_d = hold_cnt_q - 1'b1;
            SLEW_RELEASE: env_d      = env_q - step_dn;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q      <= '0;
            hold_cnt_q <= '0;
            env_vld_q  <= 1'b0;
        end else begin
            env_q      <= env_d;
            hold_cnt_q <= hold_cnt_d;
            env_vld_q  <= env_vld_d;
        end
    end

    assign env     = env_q;
    assign env_vld = env_vld_q;
endmodule

// File: rtl/envelope_follower.sv
// Amplitude envelope of an offset-binary stream: rectify/scale, then slew.
// Two clocks from din_valid to amp_valid, accepts a sample every cycle, no backpressure.
module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int AMPLITUDE_BITS = DEF_AMPLITUDE_BITS,
    parameter int FRAC_BITS      = DEF_FRAC_BITS,
    parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES
) (
    input  logic                clk,
    input  logic                rst_n,
    envelope_follower_if.slave  bus
);
    localparam int ACC_BITS = AMPLITUDE_BITS + FRAC_BITS;
    localparam logic [DATA_BITS-1:0] SIGN_MASK = DATA_BITS'(sign_mask(DATA_BITS));

    logic signed [DATA_BITS-1:0] s;
    logic [31:0]                 mag;
    logic [AMPLITUDE_BITS-1:0]   target;
    logic [ACC_BITS-1:0]         tgt_acc_q, tgt_acc_d;
    logic                        v1_q, v1_d;
    logic [ACC_BITS-1:0]         env;
    logic                        env_vld;
    logic                        env_frac_unused;

    always_comb begin
        s   = $signed(bus.din ^ SIGN_MASK);
        mag = sat_abs(32'(s), DATA_BITS);
    end

    // Take the top magnitude bits; narrow samples are left-aligned with zero fill.
    generate
        if (DATA_BITS - 1 >= AMPLITUDE_BITS) begin : g_trunc
            assign target = AMPLITUDE_BITS'(mag >> (DATA_BITS - 1 - AMPLITUDE_BITS));
        end else begin : g_pad
            assign target = AMPLITUDE_BITS'(mag << (AMPLITUDE_BITS - DATA_BITS + 1));
        end
    endgenerate

    always_comb begin
        tgt_acc_d = tgt_acc_q;
        if (bus.din_valid)
            tgt_acc_d = {target, {FRAC_BITS{1'b0}}};
        v1_d = bus.din_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_acc_q <= '0;
            v1_q      <= 1'b0;
        end else begin
            tgt_acc_q <= tgt_acc_d;
            v1_q      <= v1_d;
        end
    end

    env_slew #(
        .ACC_BITS     (ACC_BITS),
        .HOLD_SAMPLES (HOLD_SAMPLES)
    ) u_slew (
        .clk           (clk),
        .rst_n         (rst_n),
        .tgt_acc       (tgt_acc_q),
        .tgt_vld       (v1_q),
        .attack_shift  (bus.attack_shift),
        .release_shift (bus.release_shift),
        .env           (env),
        .env_vld       (env_vld)
    );

    assign env_frac_unused = ^env[FRAC_BITS-1:0];
    assign bus.amplitude   = env[ACC_BITS-1 -: AMPLITUDE_BITS];
    assign bus.amp_valid   = env_vld;
endmodule

// File: tb/tb_envelope_follower.sv
// Directed scoreboard bench: dut_a holds for 4 samples, dut_b has hold disabled.
// Drivers queue hand-computed amplitudes; monitors pop and compare on amp_valid.
module tb_envelope_follower;

    typedef struct {
        int amp;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int slew_exp [18] = '{127, 191, 223, 239, 247, 251, 253,
                          254, 254, 254, 254, 254, 254, 254, 254, 254,
                          255, 255};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    envelope_follower_if #(.DATA_BITS(12), .AMPLITUDE_BITS(8)) if_a();
    envelope_follower_if #(.DATA_BITS(12), .AMPLITUDE_BITS(8)) if_b();

    envelope_follower #(
        .DATA_BITS(12), .AMPLITUDE_BITS(8), .FRAC_BITS(8), .HOLD_SAMPLES(4)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    envelope_follower #(
        .DATA_BITS(12), .AMPLITUDE_BITS(8), .FRAC_BITS(8), .HOLD_SAMPLES(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic strobe(input bit sel_b, input logic [11:0] d, input int exp_amp, input bit track);
        exp_t e;
        @(posedge clk);
        #1;
        e.amp = exp_amp;
        e.cyc = cyc;
        if (sel_b) begin
            if_b.din       = d;
            if_b.din_valid = 1'b1;
            if (track) q_b.push_back(e);
        end else begin
            if_a.din       = d;
            if_a.din_valid = 1'b1;
            if (track) q_a.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        if_a.din_valid = 1'b0;
        if_b.din_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic set_shifts(input bit sel_b, input logic [3:0] as, input logic [3:0] rs);
        @(posedge clk);
        #1;
        if (sel_b) begin
            if_b.attack_shift  = as;
            if_b.release_shift = rs;
        end else begin
            if_a.attack_shift  = as;
            if_a.release_shift = rs;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (if_a.amp_valid === 1'b1) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_valid", 1, 0);
                end else begin
                    ea = q_a.pop_front();
                    check("a_amplitude", int'(if_a.amplitude), ea.amp);
                    check("a_latency", cyc - ea.cyc, 2);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (if_b.amp_valid === 1'b1) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_valid", 1, 0);
                end else begin
                    eb = q_b.pop_front();
                    check("b_amplitude", int'(if_b.amplitude), eb.amp);
                    check("b_latency", cyc - eb.cyc, 2);
                end
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        if_a.din           = 12'hFFF;
        if_a.din_valid     = 1'b1;
        if_a.attack_shift  = 4'd0;
        if_a.release_shift = 4'd0;
        if_b.din           = 12'hFFF;
        if_b.din_valid     = 1'b1;
        if_b.attack_shift  = 4'd0;
        if_b.release_shift = 4'd0;

        // Strobing into a held reset must produce nothing.
        repeat (4) begin
            @(negedge clk);
            check("rst_amp_a", int'(if_a.amplitude), 0);
            check("rst_vld_a", int'(if_a.amp_valid), 0);
            check("rst_amp_b", int'(if_b.amplitude), 0);
            check("rst_vld_b", int'(if_b.amp_valid), 0);
        end
        @(posedge clk);
        #1;
        if_a.din_valid = 1'b0;
        if_b.din_valid = 1'b0;
        rst_n          = 1'b1;

        // Instant attack, saturation of the most negative code, then hold and release.
        strobe(0, 12'hFFF, 255, 1);
        strobe(0, 12'h000, 255, 1);
        strobe(0, 12'h800, 255, 1);
        strobe(0, 12'h800, 255, 1);
        strobe(0, 12'h800, 255, 1);
        strobe(0, 12'h800, 255, 1);
        strobe(0, 12'h800, 0,   1);
        idle(3);

        // Halving attack from zero.
        set_shifts(0, 4'd1, 4'd0);
        for (int i = 0; i < 18; i++)
            strobe(0, 12'hFFF, slew_exp[i], 1);
        idle(3);

        // Drop back to zero, then 16 back-to-back rising samples.
        set_shifts(0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++)
            strobe(0, 12'h800, 255, 1);
        strobe(0, 12'h800, 0, 1);
        for (int k = 1; k <= 16; k++)
            strobe(0, 12'(12'h800 + 8 * k), k, 1);
        idle(3);

        // Reset while a sample sits in stage 1: it must vanish and env must clear.
        strobe(0, 12'h880, 0, 0);
        @(posedge clk);
        #1;
        if_a.din_valid = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_amp_a", int'(if_a.amplitude), 0);
        idle(2);
        strobe(0, 12'h800, 0, 1);
        idle(3);

        // Hold disabled: release acts on the first quieter sample.
        strobe(1, 12'hFFF, 255, 1);
        strobe(1, 12'h800, 0,   1);
        strobe(1, 12'h808, 1,   1);
        idle(3);

        // Minimum-step release from 0x0100, probed afterwards by a /256 attack.
        set_shifts(1, 4'd0, 4'd15);
        strobe(1, 12'h800, 0, 1);
        strobe(1, 12'h800, 0, 1);
        strobe(1, 12'h800, 0, 1);
        idle(3);
        set_shifts(1, 4'd8, 4'd15);
        strobe(1, 12'hFFF, 1, 1);
        idle(3);

        for (int i = 0; i < 20; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
- Inverse of the volume path: recovers the amplitude envelope of an offset-binary audio stream, such as a voice or mixer output.
- Produces an unsigned amplitude word in the same format the amplitude modulator consumes.
- Uses a peak detector with programmable attack and release rates and a hold counter.
- Intended uses: envelope-to-filter modulation, side-chain ducking, and VU metering.

Parameters:
- DATA_BITS, 12: sample width; input is offset binary (0x800 = silence).
- AMPLITUDE_BITS, 8: output amplitude width.
- FRAC_BITS, 8: fractional bits in the envelope accumulator.
- HOLD_SAMPLES, 4: samples after an attack during which release is suppressed. The counter width is clog2(HOLD_SAMPLES+1), minimum 1.

Ports:
- clk, input, 1: system clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- din, input, DATA_BITS: offset-binary sample.
- din_valid, input, 1: single-cycle strobe qualifying din; may be asserted every cycle.
- attack_shift, input, 4: attack rate; the step is diff >> attack_shift, and 0 means instant.
- release_shift, input, 4: release rate; the step is diff >> release_shift, and 0 means instant.
- amplitude, output, AMPLITUDE_BITS: envelope, equal to env[ACC-1 -: AMPLITUDE_BITS].
- amp_valid, output, 1: pulses once per accepted sample.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - env, hold_cnt, stage-1 registers, amplitude and amp_valid all clear to 0.
  - Reset mid-stream discards any in-flight sample; no amp_valid is emitted for it.
- Stage 1 (registered when din_valid=1):
  - s = din XOR 2^(DATA_BITS-1), interpreted as signed.
  - mag = |s|, saturating, so -2^(DATA_BITS-1) maps to 2^(DATA_BITS-1)-1.
  - target = mag[DATA_BITS-2 -: AMPLITUDE_BITS], zero-padded if DATA_BITS-1 < AMPLITUDE_BITS.
  - tgt_acc = target << FRAC_BITS, width ACC = AMPLITUDE_BITS+FRAC_BITS.
  - v1 <= din_valid.
- Stage 2 (when v1=1), in priority order:
  - Attack, if tgt_acc >= env: env += max((tgt_acc-env) >> attack_shift, 1 if the difference is nonzero). hold_cnt <= HOLD_SAMPLES.
  - Hold, else if hold_cnt != 0: hold_cnt decrements; env unchanged.
  - Release, otherwise: env -= max((env-tgt_acc) >> release_shift, 1).
  - attack_shift and release_shift are sampled in this cycle.
- Step and width rules:
  - Shift values >= ACC produce a step of 1 (minimum progress).
  - env never overshoots the target in either direction, and never wraps.
- Output timing:
  - amplitude updates and amp_valid=1 two clocks after a din_valid strobe.
  - Back-to-back strobes give back-to-back amp_valid with one result per sample, in order.
- When din_valid=0, env holds. There is no time-based decay; decay is sample-driven only.
- HOLD_SAMPLES=0 disables the hold phase.

Decomposition:
- Shared package (synth_pkg):
  - Offset-binary sign-toggle mask function.
  - Saturating abs function.
  - Default AMPLITUDE_BITS/DATA_BITS constants shared with amplitude_modulator.
- One natural sub-module, env_slew: the stage-2 accumulator with attack/hold/release logic and min-step clamp.
  - Takes tgt_acc, v1, the two shifts and HOLD_SAMPLES.
  - Reusable for smoothing control-rate parameters.
- Stage 1 and output slicing stay in the top level.

Test Plan:
(all at DATA_BITS=12, AMPLITUDE_BITS=8, FRAC_BITS=8, HOLD_SAMPLES=4)
- Reset:
  - Stimulus: rst_n low with din=0xFFF and din_valid=1.
  - Response: amplitude=0 and amp_valid=0 throughout.
  - Stimulus: release rst_n.
  - Response: the first strobe gives amp_valid exactly 2 cycles later.
- Instant attack and saturation:
  - Stimulus: attack_shift=0, din=0xFFF.
  - Response: amplitude=255.
  - Stimulus: din=0x000.
  - Response: magnitude saturates to 2047, so amplitude=255.
  - Stimulus: din=0x800.
  - Response: target=0.
- Hold then release:
  - Stimulus: after the 255 peak, with release_shift=0, send five strobes of din=0x800.
  - Response: amplitude=255 for strobes 1-4 and 0 on strobe 5.
  - Stimulus: repeat with HOLD_SAMPLES=0.
  - Response: amplitude=0 on strobe 1.
- Slewed attack:
  - Stimulus: from env=0, attack_shift=1, din=0xFFF repeated.
  - Response: amplitude sequence 127, 191, 223, 239, ...; it reaches 255 and never exceeds it.
- Min-step release:
  - Stimulus: env=0x0100 (amplitude 1), release_shift=15, target 0, HOLD_SAMPLES=0.
  - Response: env decrements by 1 per strobe; amplitude reads 0 after the first strobe.
- Streaming and reset mid-stream:
  - Stimulus: din_valid every cycle for 16 cycles.
  - Response: 16 amp_valid pulses in order.
  - Stimulus: assert rst_n low for one cycle while v1=1.
  - Response: no amp_valid for the in-flight sample; env=0.
